decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter ADDRESS_BITS, default 16, giving the PC width.
REQ-002 SHALL have parameter ENABLE_M, default 1; 1 = decode RV32M, 0 = treat M-extension encodings as illegal.
REQ-003 SHALL have the following ports (clock and reset first; the single clock is clk, and reset rst_n is asynchronous and active-low):
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage accepts this cycle
- in_pc  in  ADDRESS_BITS  PC of the offered instruction
- in_instr  in  32  instruction word
- flush  in  1  discard the held instruction (branch redirect)
- out_valid  out  1  decoded bundle is valid
- out_ready  in  1  execute accepts the bundle
- out_pc  out  ADDRESS_BITS  registered PC
- out_op  out  7  instr[6:0]
- out_funct3  out  3  instr[14:12]
- out_rs1, out_rs2, out_rd  out  5 each  instr[19:15], [24:20], [11:7]
- out_wen  out  1  register-file write enable
- out_imm32  out  32  sign-extended immediate
- out_alu_control  out  6  ALU opcode
- out_mul_en, out_div_en  out  1 each  M-unit request
- out_md_op  out  2  funct3[1:0] of the M instruction
- out_illegal  out  1  undecodable instruction
- md_done  in  1  one-cycle pulse from the mul/div unit on completion
- stall_cnt  out  16  saturating count of cycles spent in MD_WAIT

Function
REQ-004 SHALL register every decoded field: a bundle accepted on cycle N appears on the out_* ports in cycle N+1 (latency 1).
REQ-005 SHALL hold one bundle; the handshake SHALL complete on in_valid && in_ready (input) and out_valid && out_ready (output).
REQ-006 SHALL implement the states IDLE (empty), FULL (bundle held) and MD_WAIT (M operation in flight).
REQ-007 SHALL drive in_ready = (IDLE) || (FULL && out_ready && !(out_mul_en || out_div_en)); in_ready SHALL be 0 in MD_WAIT.
REQ-008 SHALL make the following transitions:
- IDLE: accept -> FULL.
- FULL, output handshake of an M bundle -> MD_WAIT.
- FULL, output handshake of a non-M bundle: FULL if a new input is accepted the same cycle, else IDLE.
- MD_WAIT, md_done -> IDLE.
REQ-009 SHALL keep every out_* field stable while out_valid && !out_ready.
REQ-010 SHALL deassert out_valid in IDLE and MD_WAIT.
REQ-011 SHALL decode immediates by format:
- I: instr[31:20] sign-extended (LOAD, OP-IMM, JALR).
- S: {instr[31:25], instr[11:7]} sign-extended.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0} sign-extended.
- U: {instr[31:12], 12'b0}.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0} sign-extended.
- All other opcodes: 0.
REQ-012 SHALL drive these ALU codes:
- add/addi/load/store/lui/auipc 000000, sll 000001, slt 000010, sltu 000011, xor 000100, srl 000101, or 000110, and 000111, sub 001000, sra 001101.
- beq 010000, bne 010001, blt 010100, bge 010101, bltu 010110, bgeu 010111.
- jalr 111111; all other cases 101010.
REQ-013 SHALL set out_wen = 1 for OP, OP-IMM, LOAD, JAL, JALR, LUI and AUIPC, and SHALL set out_wen = 0 otherwise and whenever out_illegal = 1.
REQ-014 SHALL decode an OP instruction with funct7 = 0000001 as follows when ENABLE_M = 1:
- funct3[2] = 0: out_mul_en = 1.
- funct3[2] = 1: out_div_en = 1.
- out_md_op = funct3[1:0]; out_alu_control = 101010.
REQ-015 SHALL set out_illegal = 1 for an unknown opcode, an undefined funct3/funct7 combination, a branch with funct3 010 or 011, or an M encoding when ENABLE_M = 0.
REQ-016 SHALL treat flush as synchronous: in IDLE or FULL it clears out_valid next cycle and goes to IDLE, and a same-cycle input is dropped (flush wins).
REQ-017 SHALL ignore flush in MD_WAIT, because the issued M operation still completes.
REQ-018 SHALL ignore md_done outside MD_WAIT.
REQ-019 SHALL increment stall_cnt once per MD_WAIT cycle and saturate at 16'hFFFF.

Reset
REQ-020 SHALL, while rst_n = 0, force state IDLE, out_valid 0, in_ready 1 after release, stall_cnt 0, all out_* data 0 and out_alu_control 101010.
REQ-021 SHALL abandon any held bundle or MD_WAIT on reset mid-operation, with no output handshake.

Verification
REQ-022 SHALL be verified for throughput: addi x1,x2,-5 (0xFFB10093) then add, back-to-back with out_ready = 1 -> out_imm32 = 0xFFFFFFFB, alu 000000, out_wen = 1, one bundle per cycle.
REQ-023 SHALL be verified for backpressure: out_ready = 0 for 3 cycles with a held beq -> outputs stable, in_ready = 0, alu 010000, out_wen = 0.
REQ-024 SHALL be verified for the M path: issue mul (funct7 0000001, funct3 000), md_done 5 cycles later -> out_mul_en = 1, in_ready = 0 for 5 cycles, stall_cnt = 5, then IDLE.
REQ-025 SHALL be verified for flush: flush with in_valid = 1 in FULL -> out_valid = 0 next cycle and the input is not presented; flush in MD_WAIT -> no effect.
REQ-026 SHALL be verified for illegal decode: opcode 0x7F, and mul with ENABLE_M = 0 -> out_illegal = 1, out_wen = 0, alu 101010.
REQ-027 SHALL be verified for reset: rst_n low in MD_WAIT -> out_valid = 0 and stall_cnt = 0 immediately, IDLE after release.

Source files
------------

// File: rtl/decode_stage_if.sv
// decode_stage_if: groups the fetch-side input handshake, the execute-side output bundle and
// the mul/div side-band signals of decode_stage.
//   master : fetch/execute/mul-div environment (drives in_*, flush, out_ready, md_done)
//   slave  : decode_stage (drives in_ready, out_*, stall_cnt)
interface decode_stage_if #(
  parameter int unsigned ADDRESS_BITS = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [ADDRESS_BITS-1:0] in_pc;
  logic [31:0]             in_instr;
  logic                    flush;
  logic                    out_valid;
  logic                    out_ready;
  logic [ADDRESS_BITS-1:0] out_pc;
  logic [6:0]              out_op;
  logic [2:0]              out_funct3;
  logic [4:0]              out_rs1;
  logic [4:0]              out_rs2;
  logic [4:0]              out_rd;
  logic                    out_wen;
  logic [31:0]             out_imm32;
  logic [5:0]              out_alu_control;
  logic                    out_mul_en;
  logic                    out_div_en;
  logic [1:0]              out_md_op;
  logic                    out_illegal;
  logic                    md_done;
  logic [15:0]             stall_cnt;

  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready, md_done,
    input  in_ready, out_valid, out_pc, out_op, out_funct3, out_rs1, out_rs2, out_rd,
           out_wen, out_imm32, out_alu_control, out_mul_en, out_div_en, out_md_op,
           out_illegal, stall_cnt
  );

  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready, md_done,
    output in_ready, out_valid, out_pc, out_op, out_funct3, out_rs1, out_rs2, out_rd,
           out_wen, out_imm32, out_alu_control, out_mul_en, out_div_en, out_md_op,
           out_illegal, stall_cnt
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: single-entry RV32I(+M) decode pipeline stage.
// Decodes the offered instruction combinationally and registers the bundle on acceptance, so
// a bundle accepted on cycle N is presented on cycle N+1. An issued mul/div bundle parks the
// stage in StMdWait until md_done, counting stall cycles in a saturating counter.
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : decode_stage_if.slave (input handshake, output bundle, flush, md_done, stall_cnt)
module decode_stage #(
  parameter int unsigned ADDRESS_BITS = 16,
  parameter int unsigned ENABLE_M     = 1
) (
  input logic           clk,
  input logic           rst_n,
  decode_stage_if.slave bus
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [5:0] AluAdd  = 6'b000000;
  localparam logic [5:0] AluJalr = 6'b111111;
  localparam logic [5:0] AluNone = 6'b101010;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;
  localparam logic [6:0] F7Md   = 7'b0000001;

  typedef enum logic [1:0] {StIdle, StFull, StMdWait} state_e;

  state_e r_state, w_state_next;

  logic [ADDRESS_BITS-1:0] r_pc;
  logic [31:0]             r_instr_f;  // raw field bits (op/funct3/rs/rd) of the held bundle
  logic [31:0]             r_imm;
  logic [5:0]              r_alu;
  logic                    r_wen, r_mul, r_div, r_ill;
  logic [1:0]              r_md_op;
  logic [15:0]             r_stall;

  logic [31:0] w_instr;
  logic [6:0]  w_opcode, w_funct7;
  logic [2:0]  w_funct3;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_imm;
  logic [5:0]  w_alu;
  logic        w_wen, w_mul, w_div, w_ill;
  logic [1:0]  w_md_op;
  logic        w_md_held, w_in_ready, w_load;

  assign w_instr  = bus.in_instr;
  assign w_opcode = w_instr[6:0];
  assign w_funct3 = w_instr[14:12];
  assign w_funct7 = w_instr[31:25];

  assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
  assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                    w_instr[11:8], 1'b0};
  assign w_imm_u = {w_instr[31:12], 12'b0};
  assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                    w_instr[30:21], 1'b0};

  // Instruction decode. ALU codes for OP/OP-IMM/BRANCH embed funct3 in the low bits.
  always_comb begin
    w_imm   = '0;
    w_alu   = AluNone;
    w_wen   = 1'b0;
    w_mul   = 1'b0;
    w_div   = 1'b0;
    w_md_op = 2'b00;
    w_ill   = 1'b0;
    case (w_opcode)
      OpLoad: begin
        w_imm = w_imm_i;
        w_alu = AluAdd;
        w_wen = 1'b1;
        w_ill = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111);
      end
      OpStore: begin
        w_imm = w_imm_s;
        w_alu = AluAdd;
        w_ill = w_funct3[2] || (w_funct3[1:0] == 2'b11);
      end
      OpImm: begin
        w_imm = w_imm_i;
        w_wen = 1'b1;
        w_alu = {3'b000, w_funct3};
        if (w_funct3 == 3'b001) begin
          w_ill = (w_funct7 != F7Base);
        end else if (w_funct3 == 3'b101) begin
          if (w_funct7 == F7Alt) begin
            w_alu = {3'b001, w_funct3};
          end else begin
            w_ill = (w_funct7 != F7Base);
          end
        end
      end
      OpReg: begin
        w_wen = 1'b1;
        if (w_funct7 == F7Base) begin
          w_alu = {3'b000, w_funct3};
        end else if (w_funct7 == F7Alt) begin
          w_alu = {3'b001, w_funct3};
          w_ill = (w_funct3 != 3'b000) && (w_funct3 != 3'b101);
        end else if (w_funct7 == F7Md && ENABLE_M != 0) begin
          w_mul   = ~w_funct3[2];
          w_div   = w_funct3[2];
          w_md_op = w_funct3[1:0];
        end else begin
          w_ill = 1'b1;
        end
      end
      OpBranch: begin
        w_imm = w_imm_b;
        w_alu = {3'b010, w_funct3};
        w_ill = (w_funct3[2:1] == 2'b01);
      end
      OpJal: begin
        w_imm = w_imm_j;
        w_wen = 1'b1;
      end
      OpJalr: begin
        w_imm = w_imm_i;
        w_alu = AluJalr;
        w_wen = 1'b1;
        w_ill = (w_funct3 != 3'b000);
      end
      OpLui, OpAuipc: begin
        w_imm = w_imm_u;
        w_alu = AluAdd;
        w_wen = 1'b1;
      end
      default: w_ill = 1'b1;
    endcase
    if (w_ill) begin
      w_alu   = AluNone;
      w_wen   = 1'b0;
      w_mul   = 1'b0;
      w_div   = 1'b0;
      w_md_op = 2'b00;
    end
  end

  // An M bundle must not be replaced on its output handshake: the stage has to park in
  // StMdWait, so new input is refused in that cycle.
  assign w_md_held  = r_mul | r_div;
  assign w_in_ready = (r_state == StIdle) ||
                      ((r_state == StFull) && bus.out_ready && !w_md_held);
  // Flush drops a same-cycle input.
  assign w_load     = bus.in_valid && w_in_ready && !bus.flush;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (w_load) w_state_next = StFull;
      end
      StFull: begin
        if (bus.flush) begin
          w_state_next = StIdle;
        end else if (bus.out_ready) begin
          if (w_md_held)   w_state_next = StMdWait;
          else if (w_load) w_state_next = StFull;
          else             w_state_next = StIdle;
        end
      end
      StMdWait: begin
        if (bus.md_done) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_pc      <= '0;
      r_instr_f <= '0;
      r_imm     <= '0;
      r_alu     <= AluNone;
      r_wen     <= 1'b0;
      r_mul     <= 1'b0;
      r_div     <= 1'b0;
      r_md_op   <= 2'b00;
      r_ill     <= 1'b0;
      r_stall   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_pc      <= bus.in_pc;
        r_instr_f <= w_instr;
        r_imm     <= w_imm;
        r_alu     <= w_alu;
        r_wen     <= w_wen;
        r_mul     <= w_mul;
        r_div     <= w_div;
        r_md_op   <= w_md_op;
        r_ill     <= w_ill;
      end
      if ((r_state == StMdWait) && (r_stall != 16'hFFFF)) begin
        r_stall <= r_stall + 16'd1;
      end
    end
  end

  assign bus.in_ready        = w_in_ready;
  assign bus.out_valid       = (r_state == StFull);
  assign bus.out_pc          = r_pc;
  assign bus.out_op          = r_instr_f[6:0];
  assign bus.out_funct3      = r_instr_f[14:12];
  assign bus.out_rs1         = r_instr_f[19:15];
  assign bus.out_rs2         = r_instr_f[24:20];
  assign bus.out_rd          = r_instr_f[11:7];
  assign bus.out_wen         = r_wen;
  assign bus.out_imm32       = r_imm;
  assign bus.out_alu_control = r_alu;
  assign bus.out_mul_en      = r_mul;
  assign bus.out_div_en      = r_div;
  assign bus.out_md_op       = r_md_op;
  assign bus.out_illegal     = r_ill;
  assign bus.stall_cnt       = r_stall;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_stage_if #(.ADDRESS_BITS(16)) bus ();
  decode_stage_if #(.ADDRESS_BITS(16)) bus_nm ();

  decode_stage #(.ADDRESS_BITS(16), .ENABLE_M(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  decode_stage #(.ADDRESS_BITS(16), .ENABLE_M(0)) dut_nm (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_nm)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [5:0]  alu;
    logic        wen;
    logic        mul;
    logic        div;
    logic [1:0]  md_op;
    logic        ill;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [15:0] pc;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  vec_t tbl[21];
  vec_t v_beq, v_mul, v_divu, v_addi;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction and wait (bounded) for acceptance; expected result goes to the
  // scoreboard in the cycle the handshake is seen.
  task automatic send(input vec_t v, input logic [15:0] pc, output int waits);
    exp_t e;
    bit   ok;
    e.v = v;
    e.pc = pc;
    ok = 1'b0;
    waits = 0;
    bus.in_instr = v.instr;
    bus.in_pc    = pc;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(e);
        ok = 1'b1;
      end else begin
        waits++;
      end
      tick();
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: instr 0x%08h not accepted, required acceptance", v.instr);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 50 && sb.size() != 0; k++) tick();
    check(name, 32'(sb.size()), 32'd0);
  endtask

  // Output-side scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out: got bundle pc 0x%04h instr op 0x%02h, required none",
                 bus.out_pc, bus.out_op);
      end else begin
        m_e = sb.pop_front();
        check("out_pc",      32'(bus.out_pc),          32'(m_e.pc));
        check("out_op",      32'(bus.out_op),          32'(m_e.v.instr[6:0]));
        check("out_funct3",  32'(bus.out_funct3),      32'(m_e.v.instr[14:12]));
        check("out_rs1",     32'(bus.out_rs1),         32'(m_e.v.instr[19:15]));
        check("out_rs2",     32'(bus.out_rs2),         32'(m_e.v.instr[24:20]));
        check("out_rd",      32'(bus.out_rd),          32'(m_e.v.instr[11:7]));
        check("out_imm32",   bus.out_imm32,            m_e.v.imm);
        check("out_alu",     32'(bus.out_alu_control), 32'(m_e.v.alu));
        check("out_wen",     32'(bus.out_wen),         32'(m_e.v.wen));
        check("out_mul_en",  32'(bus.out_mul_en),      32'(m_e.v.mul));
        check("out_div_en",  32'(bus.out_div_en),      32'(m_e.v.div));
        check("out_md_op",   32'(bus.out_md_op),       32'(m_e.v.md_op));
        check("out_illegal", 32'(bus.out_illegal),     32'(m_e.v.ill));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int total;

    //             instr          imm           alu        wen   mul   div   mdop   ill
    tbl[0]  = '{32'hFFB10093, 32'hFFFFFFFB, 6'b000000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[1]  = '{32'h002081B3, 32'h00000000, 6'b000000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[2]  = '{32'h407302B3, 32'h00000000, 6'b001000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[3]  = '{32'h4020D233, 32'h00000000, 6'b001101, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[4]  = '{32'h003130B3, 32'h00000000, 6'b000011, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[5]  = '{32'h003170B3, 32'h00000000, 6'b000111, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[6]  = '{32'h00812083, 32'h00000008, 6'b000000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[7]  = '{32'hFE312E23, 32'hFFFFFFFC, 6'b000000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[8]  = '{32'h00208863, 32'h00000010, 6'b010000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[9]  = '{32'hFE209CE3, 32'hFFFFFFF8, 6'b010001, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[10] = '{32'h0020F863, 32'h00000010, 6'b010111, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[11] = '{32'h0020A863, 32'h00000010, 6'b101010, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1};
    tbl[12] = '{32'h123452B7, 32'h12345000, 6'b000000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[13] = '{32'hFFFFF097, 32'hFFFFF000, 6'b000000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[14] = '{32'h001000EF, 32'h00000800, 6'b101010, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[15] = '{32'hFFFFF06F, 32'hFFFFFFFE, 6'b101010, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[16] = '{32'h004100E7, 32'h00000004, 6'b111111, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[17] = '{32'h00311093, 32'h00000003, 6'b000001, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[18] = '{32'h40315093, 32'h00000403, 6'b001101, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[19] = '{32'h0000007F, 32'h00000000, 6'b101010, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1};
    tbl[20] = '{32'h04000033, 32'h00000000, 6'b101010, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1};
    v_beq  = tbl[8];
    v_addi = tbl[0];
    v_mul  = '{32'h023100B3, 32'h00000000, 6'b101010, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0};
    v_divu = '{32'h023150B3, 32'h00000000, 6'b101010, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0};

    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0; bus.flush = 1'b0;
    bus.out_ready = 1'b0; bus.md_done = 1'b0;
    bus_nm.in_valid = 1'b0; bus_nm.in_pc = '0; bus_nm.in_instr = '0; bus_nm.flush = 1'b0;
    bus_nm.out_ready = 1'b1; bus_nm.md_done = 1'b0;

    // Reset state.
    repeat (2) tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    check("rst_alu", 32'(bus.out_alu_control), 32'(6'b101010));
    check("rst_imm", bus.out_imm32, 32'd0);
    check("rst_pc", 32'(bus.out_pc), 32'd0);
    check("rst_wen", 32'(bus.out_wen), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Back-to-back stream, out_ready held high: one bundle per cycle.
    bus.out_ready = 1'b1;
    total = 0;
    for (int i = 0; i < 21; i++) begin
      send(tbl[i], 16'(16'h0100 + 4 * i), w);
      total += w;
    end
    bus.in_valid = 1'b0;
    wait_drain("stream_drain");
    check("stream_waits", 32'(total), 32'd0);

    // Backpressure with a held beq; md_done outside MD_WAIT must be ignored.
    bus.out_ready = 1'b0;
    send(v_beq, 16'h0200, w);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) bus.md_done = 1'b1;
      @(negedge clk);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_alu", 32'(bus.out_alu_control), 32'(6'b010000));
      check("bp_wen", 32'(bus.out_wen), 32'd0);
      check("bp_imm", bus.out_imm32, 32'h00000010);
      check("bp_pc", 32'(bus.out_pc), 32'h0200);
      tick();
      bus.md_done = 1'b0;
    end
    bus.out_ready = 1'b1;
    wait_drain("bp_drain");

    // M path: mul, md_done on the 5th MD_WAIT cycle; flush and input ignored meanwhile.
    send(v_mul, 16'h0300, w);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("m_full_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    bus.in_instr = v_addi.instr;
    bus.in_pc = 16'h0304;
    bus.in_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      if (k == 3) bus.flush = 1'b1;
      if (k == 5) bus.md_done = 1'b1;
      @(negedge clk);
      check("mw_in_ready", 32'(bus.in_ready), 32'd0);
      check("mw_out_valid", 32'(bus.out_valid), 32'd0);
      tick();
      bus.flush = 1'b0;
      bus.md_done = 1'b0;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("m_stall_cnt", 32'(bus.stall_cnt), 32'd5);
    check("m_idle_in_ready", 32'(bus.in_ready), 32'd1);
    check("m_idle_out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    wait_drain("m_drain");

    // Flush in FULL with a competing input: held bundle discarded, input dropped.
    bus.out_ready = 1'b0;
    send(v_addi, 16'h0400, w);
    void'(sb.pop_back());
    bus.flush = 1'b1;
    bus.in_instr = tbl[1].instr;
    bus.in_valid = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_full_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_full_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    // Flush in IDLE while in_ready = 1: input must not be presented.
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_idle_out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    @(negedge clk);
    check("flush_idle_out_valid2", 32'(bus.out_valid), 32'd0);
    tick();
    bus.out_ready = 1'b1;
    check("flush_stall_cnt", 32'(bus.stall_cnt), 32'd5);

    // ENABLE_M = 0: mul decodes as illegal and never parks the stage.
    bus_nm.in_instr = v_mul.instr;
    bus_nm.in_pc = 16'h0044;
    bus_nm.in_valid = 1'b1;
    @(negedge clk);
    check("nm_in_ready", 32'(bus_nm.in_ready), 32'd1);
    tick();
    bus_nm.in_valid = 1'b0;
    @(negedge clk);
    check("nm_out_valid", 32'(bus_nm.out_valid), 32'd1);
    check("nm_illegal", 32'(bus_nm.out_illegal), 32'd1);
    check("nm_wen", 32'(bus_nm.out_wen), 32'd0);
    check("nm_alu", 32'(bus_nm.out_alu_control), 32'(6'b101010));
    check("nm_mul_en", 32'(bus_nm.out_mul_en), 32'd0);
    check("nm_pc", 32'(bus_nm.out_pc), 32'h0044);
    tick();
    @(negedge clk);
    check("nm_idle_in_ready", 32'(bus_nm.in_ready), 32'd1);
    tick();

    // Reset while in MD_WAIT (divu).
    send(v_divu, 16'h0500, w);
    bus.in_valid = 1'b0;
    repeat (3) tick();
    check("pre_rst_stall_cnt", 32'(bus.stall_cnt), 32'd7);
    check("pre_rst_in_ready", 32'(bus.in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    check("mrst_alu", 32'(bus.out_alu_control), 32'(6'b101010));
    check("mrst_div_en", 32'(bus.out_div_en), 32'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    check("post_rst_sb_empty", 32'(sb.size()), 32'd0);
    tick();

    // Normal operation resumes after reset.
    send(v_addi, 16'h0600, w);
    bus.in_valid = 1'b0;
    wait_drain("post_rst_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
